serial_receiver: RTL and testbench

- Receive side of the serial link; sits directly downstream of the serial transmitter and consumes its line output.
- Deserialises one frame per transaction, one bit per clk with no baud divider: start bit (0), DATA_BITS data bits LSB first, even parity bit, stop bit (1).
- Presents the received word in a holding register with a valid/ack handshake, plus parity, framing and overrun status.

---
 rtl/serial_pkg.sv | 17 +
 rtl/serial_rx_holding.sv | 48 ++++
 rtl/serial_receiver.sv | 83 ++++++++
 tb/tb_serial_receiver.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/serial_pkg.sv
// Shared definitions for both ends of the serial link: frame constants,
// default word width and the receiver FSM state encoding.
package serial_pkg;

  localparam int DEFAULT_DATA_BITS = 7;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DATA   = 3'd1,
    ST_PARITY = 3'd2,
    ST_STOP   = 3'd3
  } rx_state_t;

endpackage

// File: rtl/serial_rx_holding.sv
// Holding register for received words: valid/ack handshake, error flags
// and sticky overrun, with commit/ack arbitration on the same edge.
module serial_rx_holding
  import serial_pkg::*;
#(
  parameter int DATA_BITS = DEFAULT_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 commit,
  input  logic [DATA_BITS-1:0] word,
  input  logic                 parity_err_in,
  input  logic                 frame_err_in,
  input  logic                 data_ack,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun
);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      data_out   <= '0;
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else if (commit && (!data_valid || data_ack)) begin
      data_out   <= word;
      data_valid <= 1'b1;
      parity_err <= parity_err_in;
      frame_err  <= frame_err_in;
      // An ack on the commit edge drains the old word, which clears overrun.
      if (data_ack)
        overrun <= 1'b0;
    end else if (commit) begin
      // Pending word not taken: drop the new frame and flag it.
      overrun <= 1'b1;
    end else if (data_ack && data_valid) begin
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end
  end

endmodule

// File: rtl/serial_receiver.sv
// Serial link receiver: one bit per clk, start / DATA_BITS data LSB first /
// even parity / stop, handing completed frames to the holding register.
module serial_receiver
  import serial_pkg::*;
#(
  parameter int DATA_BITS = DEFAULT_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 serial_in,
  input  logic                 data_ack,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun
);

  rx_state_t            state;
  logic [2:0]           cnt;
  logic [DATA_BITS-1:0] shift;
  logic                 par;

  logic commit;
  logic parity_err_in;
  logic frame_err_in;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= ST_IDLE;
      cnt   <= 3'd0;
      shift <= '0;
      par   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (serial_in == START_BIT) begin
            state <= ST_DATA;
            cnt   <= 3'd0;
          end
        end
        ST_DATA: begin
          shift[cnt] <= serial_in;
          if (cnt == 3'(DATA_BITS - 1))
            state <= ST_PARITY;
          else
            cnt <= cnt + 3'd1;
        end
        ST_PARITY: begin
          par   <= serial_in;
          state <= ST_STOP;
        end
        ST_STOP: begin
          // The stop bit is consumed by the holding register on this edge.
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign commit        = (state == ST_STOP);
  assign parity_err_in = (^shift) ^ par;
  assign frame_err_in  = (serial_in != STOP_BIT);

  serial_rx_holding #(
    .DATA_BITS (DATA_BITS)
  ) u_holding (
    .clk           (clk),
    .rstn          (rstn),
    .commit        (commit),
    .word          (shift),
    .parity_err_in (parity_err_in),
    .frame_err_in  (frame_err_in),
    .data_ack      (data_ack),
    .data_out      (data_out),
    .data_valid    (data_valid),
    .parity_err    (parity_err),
    .frame_err     (frame_err),
    .overrun       (overrun)
  );

endmodule

// File: tb/tb_serial_receiver.sv
// Directed bench for serial_receiver: table of single frames plus hand-written
// overrun, reset, loopback and stuck-line sequences.
module tb_serial_receiver;

  localparam int DATA_BITS = 7;

  logic                 clk = 1'b0;
  logic                 rstn = 1'b0;
  logic                 serial_in = 1'b1;
  logic                 data_ack = 1'b0;
  logic [DATA_BITS-1:0] data_out;
  logic                 data_valid;
  logic                 parity_err;
  logic                 frame_err;
  logic                 overrun;

  int errors = 0;
  int checks = 0;

  serial_receiver #(.DATA_BITS(DATA_BITS)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .serial_in  (serial_in),
    .data_ack   (data_ack),
    .data_out   (data_out),
    .data_valid (data_valid),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DATA_BITS-1:0] d;
    logic                 p;
    logic                 s;
    logic                 exp_perr;
    logic                 exp_ferr;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1 time unit after it.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [DATA_BITS-1:0] d, input logic p, input logic s,
                            input logic ack_on_stop, input logic chk_pre);
    serial_in = 1'b0;
    tick();
    for (int i = 0; i < DATA_BITS; i++) begin
      serial_in = d[i];
      tick();
    end
    serial_in = p;
    tick();
    if (chk_pre) chk("valid_before_stop", 32'(data_valid), 32'd0);
    serial_in = s;
    data_ack  = ack_on_stop;
    tick();
    data_ack  = 1'b0;
    serial_in = 1'b1;
  endtask

  task automatic ack_cycle;
    data_ack = 1'b1;
    tick();
    data_ack = 1'b0;
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_data"},  32'(data_out),   32'd0);
    chk({name, "_valid"}, 32'(data_valid), 32'd0);
    chk({name, "_perr"},  32'(parity_err), 32'd0);
    chk({name, "_ferr"},  32'(frame_err),  32'd0);
    chk({name, "_ovr"},   32'(overrun),    32'd0);
  endtask

  logic [DATA_BITS-1:0] lb [3];

  initial begin
    vecs[0] = '{d: 7'h55, p: 1'b0, s: 1'b1, exp_perr: 1'b0, exp_ferr: 1'b0};
    vecs[1] = '{d: 7'h23, p: 1'b0, s: 1'b1, exp_perr: 1'b1, exp_ferr: 1'b0};
    vecs[2] = '{d: 7'h7F, p: 1'b1, s: 1'b0, exp_perr: 1'b0, exp_ferr: 1'b1};
    vecs[3] = '{d: 7'h00, p: 1'b0, s: 1'b1, exp_perr: 1'b0, exp_ferr: 1'b0};
    vecs[4] = '{d: 7'h01, p: 1'b0, s: 1'b0, exp_perr: 1'b1, exp_ferr: 1'b1};
    vecs[5] = '{d: 7'h40, p: 1'b1, s: 1'b1, exp_perr: 1'b0, exp_ferr: 1'b0};

    // Reset state, then a long idle line must not produce a word.
    #2;
    chk_all_zero("reset");
    tick();
    rstn = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    chk("idle_valid", 32'(data_valid), 32'd0);
    rstn = 1'b0;
    #1;
    chk_all_zero("reset_idle");
    rstn = 1'b1;
    tick();

    // Single frames from the table, each acknowledged.
    for (int v = 0; v < 6; v++) begin
      send_frame(vecs[v].d, vecs[v].p, vecs[v].s, 1'b0, 1'b1);
      chk($sformatf("v%0d_data", v),  32'(data_out),   32'(vecs[v].d));
      chk($sformatf("v%0d_valid", v), 32'(data_valid), 32'd1);
      chk($sformatf("v%0d_perr", v),  32'(parity_err), 32'(vecs[v].exp_perr));
      chk($sformatf("v%0d_ferr", v),  32'(frame_err),  32'(vecs[v].exp_ferr));
      chk($sformatf("v%0d_ovr", v),   32'(overrun),    32'd0);
      ack_cycle();
      chk($sformatf("v%0d_ack_valid", v), 32'(data_valid), 32'd0);
      chk($sformatf("v%0d_ack_perr", v),  32'(parity_err), 32'd0);
      chk($sformatf("v%0d_ack_ferr", v),  32'(frame_err),  32'd0);
    end

    // Back-to-back frames with no idle gap and no ack: second is dropped.
    send_frame(7'h11, 1'b0, 1'b1, 1'b0, 1'b0);
    send_frame(7'h22, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("ovr_data",  32'(data_out),   32'h11);
    chk("ovr_valid", 32'(data_valid), 32'd1);
    chk("ovr_flag",  32'(overrun),    32'd1);
    ack_cycle();
    chk("ovr_ack_valid", 32'(data_valid), 32'd0);
    chk("ovr_ack_flag",  32'(overrun),    32'd0);

    // Ack on the same edge as the second commit loads the new word.
    send_frame(7'h11, 1'b0, 1'b1, 1'b0, 1'b0);
    send_frame(7'h22, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("coack_data",  32'(data_out),   32'h22);
    chk("coack_valid", 32'(data_valid), 32'd1);
    chk("coack_ovr",   32'(overrun),    32'd0);
    ack_cycle();

    // Word pending, then reset after three data bits: outputs cleared, frame lost.
    send_frame(7'h55, 1'b0, 1'b1, 1'b0, 1'b0);
    serial_in = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      serial_in = 1'b0;
      tick();
    end
    rstn = 1'b0;
    #1;
    chk_all_zero("midframe_rst");
    tick();
    rstn = 1'b1;
    serial_in = 1'b1;
    for (int i = 0; i < 12; i++) tick();
    chk("midframe_no_commit", 32'(data_valid), 32'd0);

    // Loopback: transmitter-style frames with correct parity and one idle cycle.
    lb[0] = 7'h00;
    lb[1] = 7'h7F;
    lb[2] = 7'h5A;
    for (int k = 0; k < 3; k++) begin
      send_frame(lb[k], ^lb[k], 1'b1, 1'b0, 1'b0);
      chk($sformatf("lb%0d_data", k),  32'(data_out),   32'(lb[k]));
      chk($sformatf("lb%0d_valid", k), 32'(data_valid), 32'd1);
      chk($sformatf("lb%0d_perr", k),  32'(parity_err), 32'd0);
      chk($sformatf("lb%0d_ferr", k),  32'(frame_err),  32'd0);
      ack_cycle();
    end

    // Line stuck low: frames keep re-triggering and report framing errors.
    serial_in = 1'b0;
    for (int i = 0; i < DATA_BITS + 3; i++) tick();
    chk("stuck_valid", 32'(data_valid), 32'd1);
    chk("stuck_ferr",  32'(frame_err),  32'd1);
    chk("stuck_perr",  32'(parity_err), 32'd0);
    chk("stuck_data",  32'(data_out),   32'd0);
    data_ack = 1'b1;
    tick();
    data_ack = 1'b0;
    for (int i = 0; i < DATA_BITS + 2; i++) tick();
    chk("stuck_again_valid", 32'(data_valid), 32'd1);
    chk("stuck_again_ferr",  32'(frame_err),  32'd1);
    serial_in = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
